// File: rtl/video_timing_gen_if.sv
// Pixel-stream bundle from the timing generator to the three TMDS channel encoders.
// Everything in the bundle is registered in the pixel clock domain, and all signals are aligned.
interface video_timing_gen_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  modport master (
    output hsync, vsync, de, x, y, frame_start, red, green, blue
  );

  modport slave (
    input  hsync, vsync, de, x, y, frame_start, red, green, blue
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with a built-in test-pattern source.
// The h/v counters hold the position that the next clock edge decodes. Every output is
// decoded from the current counter values and registered at the same edge, so all
// outputs carry the same one-cycle latency.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic                      i_pixclk,
  input  logic                      i_reset_n,
  input  logic [1:0]                i_pattern_sel,
  input  logic [23:0]               i_solid_rgb,
  video_timing_gen_if.master        vid
);

  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BAR_LAST   = 12'(H_ACTIVE / 8 - 1);

  // Position counters and the colour-bar width counter.
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] bar_px_q, bar_px_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  pat_q;

  // Registered outputs.
  logic        hsync_q, vsync_q, de_q, frame_start_q;
  logic [11:0] x_q, y_q;
  logic [23:0] rgb_q;

  // Decode of the current position.
  logic        h_wrap_s, de_s, hs_act_s, vs_act_s, origin_s;
  logic [1:0]  pat_s;
  logic [23:0] bar_rgb_s, rgb_s;

  // Next-state logic for the counters. The bar counter restarts on every line, so the
  // bar index is available without dividing x.
  always_comb begin
    h_wrap_s  = (h_cnt_q == H_LAST);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_wrap_s) begin
      h_cnt_d   = 12'd0;
      bar_px_d  = 12'd0;
      bar_idx_d = 3'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 12'd0;
      end else begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = 12'd0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d  = bar_px_q + 12'd1;
      end
    end
  end

  // Timing flags for the current position. The pattern select passes through only at
  // the frame origin, so the first pixel of a frame already uses the new pattern.
  always_comb begin
    de_s     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_act_s = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    vs_act_s = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    origin_s = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    if (origin_s) begin
      pat_s = i_pattern_sel;
    end else begin
      pat_s = pat_q;
    end
  end

  // Colour for each bar position: full-level components only.
  always_comb begin
    case (bar_idx_q)
      3'd0:    bar_rgb_s = 24'hFFFFFF;
      3'd1:    bar_rgb_s = 24'hFFFF00;
      3'd2:    bar_rgb_s = 24'h00FFFF;
      3'd3:    bar_rgb_s = 24'h00FF00;
      3'd4:    bar_rgb_s = 24'hFF00FF;
      3'd5:    bar_rgb_s = 24'hFF0000;
      3'd6:    bar_rgb_s = 24'h0000FF;
      default: bar_rgb_s = 24'h000000;
    endcase
  end

  // Pattern multiplexer. Blanking always outputs black.
  always_comb begin
    case (pat_s)
      2'd0:    rgb_s = bar_rgb_s;
      2'd1:    rgb_s = {24{h_cnt_q[5] ^ v_cnt_q[5]}};
      2'd2:    rgb_s = {h_cnt_q[9:2], h_cnt_q[9:2], h_cnt_q[9:2]};
      2'd3:    rgb_s = i_solid_rgb;
      default: rgb_s = 24'h000000;
    endcase
    if (!de_s) begin
      rgb_s = 24'h000000;
    end else begin
      rgb_s = rgb_s;
    end
  end

  // Advance the counters and register the decoded outputs. Reset forces the idle state.
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      bar_px_q      <= 12'd0;
      bar_idx_q     <= 3'd0;
      pat_q         <= i_pattern_sel;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      rgb_q         <= 24'h000000;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
      pat_q         <= pat_s;
      hsync_q       <= hs_act_s ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_act_s ? VSYNC_POL : ~VSYNC_POL;
      de_q          <= de_s;
      frame_start_q <= origin_s;
      x_q           <= de_s ? h_cnt_q : 12'd0;
      y_q           <= de_s ? v_cnt_q : 12'd0;
      rgb_q         <= rgb_s;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.frame_start = frame_start_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.red         = rgb_q[23:16];
  assign vid.green       = rgb_q[15:8];
  assign vid.blue        = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so that whole frames fit in a short run.
// Geometry: H 64+8+12+6 = 90, V 40+3+2+4 = 49. Frame = 4410 cycles.
// Bars are 8 px wide. hsync is low for h in [72,84). vsync is low for lines [43,45).
module tb_video_timing_gen;

  localparam int HT    = 90;
  localparam int FRAME = 90 * 49;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;

  int checks   = 0;
  int failures = 0;

  video_timing_gen_if vid();

  video_timing_gen #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(12), .H_BP(6),
    .V_ACTIVE(40), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .i_pixclk      (clk),
    .i_reset_n     (rst_n),
    .i_pattern_sel (pattern_sel),
    .i_solid_rgb   (solid_rgb),
    .vid           (vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [23:0] solid;
    int          h;
    int          v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] sel, input logic [23:0] solid,
                              input int h, input int v,
                              input logic de, input logic hs, input logic vs, input logic fs,
                              input int x, input int y, input logic [23:0] rgb);
    vec_t r;
    r.sel = sel; r.solid = solid; r.h = h; r.v = v;
    r.de = de; r.hs = hs; r.vs = vs; r.fs = fs;
    r.x = x; r.y = y; r.rgb = rgb;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One reset edge, then release; the next tick decodes position (0,0).
  task automatic do_reset(input logic [1:0] sel, input logic [23:0] solid);
    rst_n       = 1'b0;
    pattern_sel = sel;
    solid_rgb   = solid;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_fs(input int budget, output int period);
    period = 0;
    do begin
      tick();
      period++;
    end while (!vid.frame_start && period < budget);
  endtask

  function automatic logic [23:0] rgb_now();
    return {vid.red, vid.green, vid.blue};
  endfunction

  initial begin
    int period;
    int de_cnt, hs_cnt, vs_cnt, de_rise, max_x, max_y;
    logic prev_de;

    rst_n       = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 24'h000000;

    // Reset held for 5 cycles
    repeat (5) tick();
    chk("rst.hsync", 32'(vid.hsync), 32'd1);
    chk("rst.vsync", 32'(vid.vsync), 32'd1);
    chk("rst.de", 32'(vid.de), 32'd0);
    chk("rst.fs", 32'(vid.frame_start), 32'd0);
    chk("rst.rgb", 32'(rgb_now()), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel.de", 32'(vid.de), 32'd1);
    chk("rel.fs", 32'(vid.frame_start), 32'd1);
    chk("rel.x", 32'(vid.x), 32'd0);
    chk("rel.y", 32'(vid.y), 32'd0);

    // Table of directed positions
    vecs.push_back(mk(2'd0, 24'h0,      0,  0, 1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 24'hFFFFFF));
    vecs.push_back(mk(2'd0, 24'h0,      8,  0, 1'b1, 1'b1, 1'b1, 1'b0,  8,  0, 24'hFFFF00));
    vecs.push_back(mk(2'd0, 24'h0,     40,  1, 1'b1, 1'b1, 1'b1, 1'b0, 40,  1, 24'hFF0000));
    vecs.push_back(mk(2'd0, 24'h0,     63,  2, 1'b1, 1'b1, 1'b1, 1'b0, 63,  2, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     64,  2, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     71,  3, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     72,  2, 1'b0, 1'b0, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     83,  2, 1'b0, 1'b0, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     84,  2, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd1, 24'h0,     31,  0, 1'b1, 1'b1, 1'b1, 1'b0, 31,  0, 24'h000000));
    vecs.push_back(mk(2'd1, 24'h0,     32,  0, 1'b1, 1'b1, 1'b1, 1'b0, 32,  0, 24'hFFFFFF));
    vecs.push_back(mk(2'd1, 24'h0,      0, 33, 1'b1, 1'b1, 1'b1, 1'b0,  0, 33, 24'hFFFFFF));
    vecs.push_back(mk(2'd1, 24'h0,     40, 33, 1'b1, 1'b1, 1'b1, 1'b0, 40, 33, 24'h000000));
    vecs.push_back(mk(2'd2, 24'h0,     44,  3, 1'b1, 1'b1, 1'b1, 1'b0, 44,  3, 24'h0B0B0B));
    vecs.push_back(mk(2'd2, 24'h0,     63,  3, 1'b1, 1'b1, 1'b1, 1'b0, 63,  3, 24'h0F0F0F));
    vecs.push_back(mk(2'd3, 24'h123456, 10, 5, 1'b1, 1'b1, 1'b1, 1'b0, 10,  5, 24'h123456));
    vecs.push_back(mk(2'd3, 24'h123456, 70, 5, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,      0, 40, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     89, 42, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,      0, 43, 1'b0, 1'b1, 1'b0, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     75, 43, 1'b0, 1'b0, 1'b0, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     89, 44, 1'b0, 1'b1, 1'b0, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,      0, 45, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));
    vecs.push_back(mk(2'd0, 24'h0,     89, 48, 1'b0, 1'b1, 1'b1, 1'b0,  0,  0, 24'h000000));

    foreach (vecs[i]) begin
      do_reset(vecs[i].sel, vecs[i].solid);
      repeat (vecs[i].v * HT + vecs[i].h + 1) tick();
      chk($sformatf("v%0d.de", i),  32'(vid.de),          32'(vecs[i].de));
      chk($sformatf("v%0d.hs", i),  32'(vid.hsync),       32'(vecs[i].hs));
      chk($sformatf("v%0d.vs", i),  32'(vid.vsync),       32'(vecs[i].vs));
      chk($sformatf("v%0d.fs", i),  32'(vid.frame_start), 32'(vecs[i].fs));
      chk($sformatf("v%0d.x", i),   32'(vid.x),           32'(vecs[i].x));
      chk($sformatf("v%0d.y", i),   32'(vid.y),           32'(vecs[i].y));
      chk($sformatf("v%0d.rgb", i), 32'(rgb_now()),       32'(vecs[i].rgb));
    end

    // Whole-frame statistics: one frame_start period, accumulated over positions 0..FRAME-1
    do_reset(2'd0, 24'h0);
    tick();
    chk("frm.fs0", 32'(vid.frame_start), 32'd1);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; de_rise = 0; max_x = 0; max_y = 0;
    prev_de = 1'b0;
    period = 0;
    for (int n = 0; n < 10000; n++) begin
      if (n > 0) begin
        tick();
        period++;
        if (vid.frame_start) break;
      end
      if (vid.de) de_cnt++;
      if (!vid.hsync) hs_cnt++;
      if (!vid.vsync) vs_cnt++;
      if (vid.de && !prev_de) de_rise++;
      prev_de = vid.de;
      if (int'(vid.x) > max_x) max_x = int'(vid.x);
      if (int'(vid.y) > max_y) max_y = int'(vid.y);
    end
    chk("frm.period", 32'(period), 32'(FRAME));
    chk("frm.de_cnt", 32'(de_cnt), 32'd2560);
    chk("frm.hs_cnt", 32'(hs_cnt), 32'd588);
    chk("frm.vs_cnt", 32'(vs_cnt), 32'd180);
    chk("frm.lines", 32'(de_rise), 32'd40);
    chk("frm.max_x", 32'(max_x), 32'd63);
    chk("frm.max_y", 32'(max_y), 32'd39);

    // Pattern switch mid-frame: bars remain until the next frame start
    do_reset(2'd0, 24'h0);
    repeat (10 * HT + 1) tick();
    pattern_sel = 2'd3;
    solid_rgb   = 24'h123456;
    repeat (10 * HT) tick();
    chk("sw.same_frame_y", 32'(vid.y), 32'd20);
    chk("sw.same_frame_rgb", 32'(rgb_now()), 32'hFFFFFF);
    wait_fs(2 * FRAME, period);
    chk("sw.fs_wait", 32'(vid.frame_start), 32'd1);
    chk("sw.first_px", 32'(rgb_now()), 32'h123456);
    repeat (63) tick();
    chk("sw.last_px_x", 32'(vid.x), 32'd63);
    chk("sw.last_px", 32'(rgb_now()), 32'h123456);

    // Reset mid-frame at line 30
    do_reset(2'd0, 24'h0);
    repeat (30 * HT + 1) tick();
    chk("mr.pre_y", 32'(vid.y), 32'd30);
    rst_n = 1'b0;
    tick();
    chk("mr.rst_de", 32'(vid.de), 32'd0);
    chk("mr.rst_hs", 32'(vid.hsync), 32'd1);
    chk("mr.rst_vs", 32'(vid.vsync), 32'd1);
    chk("mr.rst_rgb", 32'(rgb_now()), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mr.fs", 32'(vid.frame_start), 32'd1);
    chk("mr.de", 32'(vid.de), 32'd1);
    chk("mr.xy", 32'({vid.x, vid.y}), 32'd0);
    chk("mr.rgb", 32'(rgb_now()), 32'hFFFFFF);
    wait_fs(2 * FRAME, period);
    chk("mr.period", 32'(period), 32'(FRAME));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
